typec_src_attach_ctrl: RTL and testbench
========================================

// Module: typec_src_attach_ctrl
// PURPOSE
//  Type-C source-role attach/detach sequencer for one CC1/CC2 port pair.
//  - Inputs: digitised CC comparator results (Rd window, Ra window) and VBUS-level flags.
//  - Outputs: DUT_RP1/2_EN, DUT_RP_SEL, DUT_VCONN1/2_EN, CC_SEL, VBUS gate and discharge.
//  - Sits between the CC comparators and the usb_connector pad controls.
//  - Sequences debounce, orientation latch, VBUS/VCONN enable and detach discharge.
// PARAMETERS
//  CNT_W     16     width of the shared timer counter
//  T_CCDB    15000  tCCDebounce in clk cycles (attach debounce)
//  T_PDDB    1500   tPDDebounce in clk cycles (detach debounce)
//  T_DISCHG  65000  maximum discharge time in clk cycles, >0
// PORTS
//  clk           in   1  single clock; all logic on rising edge
//  srstz         in   1  synchronous reset, active low
//  en            in   1  controller enable; 0 forces DISABLED
//  rp_sel_cfg    in   2  Rp strength: 0=default(36K), 1=1.5A(12K), 2/3=3A(4.7K)
//  vconn_allow   in   1  permit VCONN sourcing
//  cc1_rd        in   1  CC1 voltage inside Rd window
//  cc2_rd        in   1  CC2 voltage inside Rd window
//  cc1_ra        in   1  CC1 voltage inside Ra window
//  cc2_ra        in   1  CC2 voltage inside Ra window
//  vbus_safe0v   in   1  VBUS below vSafe0V
//  DUT_RP1_EN    out  1  Rp enable on CC1
//  DUT_RP2_EN    out  1  Rp enable on CC2
//  DUT_RP_SEL    out  2  registered copy of rp_sel_cfg
//  DUT_VCONN1_EN out  1  VCONN drive on CC1
//  DUT_VCONN2_EN out  1  VCONN drive on CC2
//  CC_SEL        out  1  orientation, 0=CC1 is active CC, 1=CC2
//  GATE_EN       out  1  VBUS power switch enable
//  DISCHG_EN     out  1  VBUS discharge enable
//  attached      out  1  high in ATTACHED and DET_WAIT
//  state         out  3  current FSM state code
// BEHAVIOUR
//  Reset (srstz=0 at edge): state=DISABLED(0), timer=0, all outputs 0 incl. CC_SEL/RP_SEL.
//  All outputs are registered and track the state they belong to on the same edge the state is entered.
//  States: DISABLED=0, UNATT=1, ATT_WAIT=2, ATTACHED=3, DET_WAIT=4, DISCHG=5.
//  DISABLED: every output 0. en=1 -> UNATT.
//  en=0 in any state -> DISABLED next edge. This drops GATE/VCONN/DISCHG immediately.
//  UNATT: RP1/RP2=1; DUT_RP_SEL<=rp_sel_cfg; GATE/VCONN/DISCHG=0.
//   - Qualifying pattern A: cc1_rd & ~cc2_rd -> ori=0.
//   - Qualifying pattern B: cc2_rd & ~cc1_rd -> ori=1.
//   - A or B -> ATT_WAIT; latch ori; timer=0.
//   - Both Rd (debug accessory) or neither Rd -> stay in UNATT.
//  ATT_WAIT: timer increments each cycle while the latched pattern holds.
//   - Pattern changes -> UNATT, timer=0.
//   - timer==T_CCDB-1 & vbus_safe0v -> ATTACHED.
//   - timer==T_CCDB-1 & ~vbus_safe0v -> hold timer saturated and wait.
//  ATTACHED: CC_SEL=ori; GATE_EN=1; Rp kept on active CC only, inactive Rp=0.
//   - VCONN on inactive CC = vconn_allow & ra on inactive CC, sampled on entry.
//   - vconn_allow falling -> that VCONN off next cycle.
//   - Active-CC rd=0 -> DET_WAIT, timer=0.
//  DET_WAIT: outputs as in ATTACHED.
//   - Active-CC rd back to 1 -> ATTACHED, timer=0.
//   - timer==T_PDDB-1 -> DISCHG.
//  DISCHG: GATE=0, VCONN=0, DISCHG_EN=1, RP on both CCs; timer=0 on entry.
//   - vbus_safe0v=1 or timer==T_DISCHG-1 -> UNATT; DISCHG_EN=0 on that edge.
//  Timer: CNT_W bits, saturating, never wraps; cleared on every state change.
//  rp_sel_cfg change while attached: DUT_RP_SEL follows next cycle, no state change.
//  Simultaneous en=0 and any transition condition: en=0 wins.
// TESTING
//  - Reset: srstz=0 for 2 clk with en=1 -> state=0, all outputs 0. Release -> state=1, RP1=RP2=1 next clk.
//  - Attach CC2: cc2_rd=1, vbus_safe0v=1, cc1_ra=1, vconn_allow=1 -> ATTACHED exactly T_CCDB clk after ATT_WAIT entry.
//    Expect CC_SEL=1, GATE_EN=1, VCONN1_EN=1, RP1=0, RP2=1.
//  - Glitch: cc1_rd high for T_CCDB-2 clk then low -> back to UNATT, GATE_EN never 1. Re-attach needs a full T_CCDB.
//  - Detach debounce: in ATTACHED drop active rd for T_PDDB-2 clk then restore -> stays attached.
//    Drop for T_PDDB clk -> DISCHG, GATE=0, DISCHG_EN=1, VCONN=0.
//  - Discharge: keep vbus_safe0v=0 -> UNATT after T_DISCHG clk. Repeat with vbus_safe0v=1 after 10 clk -> UNATT at clk 11.
//  - Mid-op en=0 / srstz=0 in ATTACHED -> all outputs 0 next edge, state=0.

Source files
------------

// File: rtl/typec_src_attach_ctrl.sv
// Type-C source attach/detach sequencer for one CC pair.
// Debounces Rd, latches orientation, drives VBUS/VCONN/discharge.
module typec_src_attach_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned T_CCDB   = 15000,
  parameter int unsigned T_PDDB   = 1500,
  parameter int unsigned T_DISCHG = 65000
) (
  input  logic       clk,
  input  logic       srstz,
  input  logic       en,
  input  logic [1:0] rp_sel_cfg,
  input  logic       vconn_allow,
  input  logic       cc1_rd,
  input  logic       cc2_rd,
  input  logic       cc1_ra,
  input  logic       cc2_ra,
  input  logic       vbus_safe0v,
  output logic       DUT_RP1_EN,
  output logic       DUT_RP2_EN,
  output logic [1:0] DUT_RP_SEL,
  output logic       DUT_VCONN1_EN,
  output logic       DUT_VCONN2_EN,
  output logic       CC_SEL,
  output logic       GATE_EN,
  output logic       DISCHG_EN,
  output logic       attached,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_DIS   = 3'd0,
    S_UNATT = 3'd1,
    S_AWAIT = 3'd2,
    S_ATT   = 3'd3,
    S_DWAIT = 3'd4,
    S_DCHG  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CCDB_M1 = CNT_W'(T_CCDB - 1);
  localparam logic [CNT_W-1:0] PDDB_M1 = CNT_W'(T_PDDB - 1);
  localparam logic [CNT_W-1:0] DCHG_M1 = CNT_W'(T_DISCHG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ori_q, ori_d;
  logic             tmr_run;
  logic             rp1_q, rp1_d, rp2_q, rp2_d;
  logic [1:0]       rpsel_q, rpsel_d;
  logic             vc1_q, vc1_d, vc2_q, vc2_d;
  logic             ccsel_q, ccsel_d;
  logic             gate_q, gate_d;
  logic             dchg_q, dchg_d;
  logic             att_q, att_d;

  logic pat_a, pat_b, pat_hold, act_rd;
  assign pat_a    = cc1_rd & ~cc2_rd;
  assign pat_b    = cc2_rd & ~cc1_rd;
  assign pat_hold = ori_q ? pat_b : pat_a;
  assign act_rd   = ori_q ? cc2_rd : cc1_rd;

  // Next state, timer and registered output values for the next state
  always_comb begin
    state_d = state_q;
    ori_d   = ori_q;
    tmr_run = 1'b0;
    case (state_q)
      S_DIS:   if (en) state_d = S_UNATT;
      S_UNATT: if (pat_a | pat_b) begin
        state_d = S_AWAIT;
        ori_d   = pat_b;
      end
      S_AWAIT: begin
        if (!pat_hold) state_d = S_UNATT;
        else if (timer_q == CCDB_M1) begin
          if (vbus_safe0v) state_d = S_ATT;
        end else tmr_run = 1'b1;
      end
      S_ATT:   if (!act_rd) state_d = S_DWAIT;
      S_DWAIT: begin
        if (act_rd) state_d = S_ATT;
        else if (timer_q == PDDB_M1) state_d = S_DCHG;
        else tmr_run = 1'b1;
      end
      S_DCHG: begin
        if (vbus_safe0v || timer_q == DCHG_M1) state_d = S_UNATT;
        else tmr_run = 1'b1;
      end
      default: state_d = S_DIS;
    endcase
    if (!en) state_d = S_DIS;

    if (state_d != state_q) timer_d = '0;
    else if (tmr_run && timer_q != '1) timer_d = timer_q + 1'b1;
    else timer_d = timer_q;

    rp1_d   = 1'b0;
    rp2_d   = 1'b0;
    rpsel_d = (state_d == S_DIS) ? 2'd0 : rp_sel_cfg;
    vc1_d   = 1'b0;
    vc2_d   = 1'b0;
    ccsel_d = 1'b0;
    gate_d  = 1'b0;
    dchg_d  = 1'b0;
    att_d   = 1'b0;
    case (state_d)
      S_UNATT, S_AWAIT: begin
        rp1_d = 1'b1;
        rp2_d = 1'b1;
      end
      S_DCHG: begin
        rp1_d  = 1'b1;
        rp2_d  = 1'b1;
        dchg_d = 1'b1;
      end
      S_ATT, S_DWAIT: begin
        rp1_d   = ~ori_d;
        rp2_d   = ori_d;
        ccsel_d = ori_d;
        gate_d  = 1'b1;
        att_d   = 1'b1;
        if (state_q == S_AWAIT) begin
          vc1_d = ori_d & vconn_allow & cc1_ra;
          vc2_d = ~ori_d & vconn_allow & cc2_ra;
        end else begin
          vc1_d = vc1_q & vconn_allow;
          vc2_d = vc2_q & vconn_allow;
        end
      end
      default: ;
    endcase
  end

  // State, timer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!srstz) begin
      state_q <= S_DIS;
      timer_q <= '0;
      ori_q   <= 1'b0;
      rp1_q   <= 1'b0;
      rp2_q   <= 1'b0;
      rpsel_q <= 2'd0;
      vc1_q   <= 1'b0;
      vc2_q   <= 1'b0;
      ccsel_q <= 1'b0;
      gate_q  <= 1'b0;
      dchg_q  <= 1'b0;
      att_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ori_q   <= ori_d;
      rp1_q   <= rp1_d;
      rp2_q   <= rp2_d;
      rpsel_q <= rpsel_d;
      vc1_q   <= vc1_d;
      vc2_q   <= vc2_d;
      ccsel_q <= ccsel_d;
      gate_q  <= gate_d;
      dchg_q  <= dchg_d;
      att_q   <= att_d;
    end
  end

  assign DUT_RP1_EN    = rp1_q;
  assign DUT_RP2_EN    = rp2_q;
  assign DUT_RP_SEL    = rpsel_q;
  assign DUT_VCONN1_EN = vc1_q;
  assign DUT_VCONN2_EN = vc2_q;
  assign CC_SEL        = ccsel_q;
  assign GATE_EN       = gate_q;
  assign DISCHG_EN     = dchg_q;
  assign attached      = att_q;
  assign state         = state_q;

endmodule

// File: tb/tb_typec_src_attach_ctrl.sv
// Directed bench for typec_src_attach_ctrl.
// Short timer parameters keep the run brief.
module tb_typec_src_attach_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned TC = 20;
  localparam int unsigned TP = 8;
  localparam int unsigned TD = 30;

  logic       clk = 1'b0;
  logic       srstz, en, vconn_allow;
  logic [1:0] rp_sel_cfg;
  logic       cc1_rd, cc2_rd, cc1_ra, cc2_ra, vbus_safe0v;
  logic       rp1, rp2, vc1, vc2, ccsel, gate, dchg, att;
  logic [1:0] rpsel;
  logic [2:0] st;

  int nvec = 0;
  int nerr = 0;
  logic gate_seen;

  typec_src_attach_ctrl #(
    .CNT_W(CW), .T_CCDB(TC), .T_PDDB(TP), .T_DISCHG(TD)
  ) dut (
    .clk(clk), .srstz(srstz), .en(en),
    .rp_sel_cfg(rp_sel_cfg), .vconn_allow(vconn_allow),
    .cc1_rd(cc1_rd), .cc2_rd(cc2_rd),
    .cc1_ra(cc1_ra), .cc2_ra(cc2_ra),
    .vbus_safe0v(vbus_safe0v),
    .DUT_RP1_EN(rp1), .DUT_RP2_EN(rp2),
    .DUT_RP_SEL(rpsel),
    .DUT_VCONN1_EN(vc1), .DUT_VCONN2_EN(vc2),
    .CC_SEL(ccsel), .GATE_EN(gate),
    .DISCHG_EN(dchg), .attached(att),
    .state(st)
  );

  always #5 clk = ~clk;

  // {RP1,RP2,RP_SEL[1:0],VCONN1,VCONN2,CC_SEL,GATE,DISCHG,attached}
  function automatic logic [9:0] outs();
    return {rp1, rp2, rpsel, vc1, vc2, ccsel, gate, dchg, att};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    srstz = 1'b0; en = 1'b1; rp_sel_cfg = 2'd2;
    vconn_allow = 1'b0; cc1_rd = 1'b0; cc2_rd = 1'b0;
    cc1_ra = 1'b0; cc2_ra = 1'b0; vbus_safe0v = 1'b1;

    tick(); tick();
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_outs", 32'(outs()), 32'h000);

    srstz = 1'b1;
    tick();
    chk("unatt_state", 32'(st), 32'd1);
    chk("unatt_outs", 32'(outs()), 32'b11_10_000000);

    // attach on CC2 with Ra on CC1
    cc2_rd = 1'b1; cc1_ra = 1'b1; vconn_allow = 1'b1;
    tick();
    chk("aw_entry", 32'(st), 32'd2);
    for (int i = 0; i < TC - 1; i++) tick();
    chk("aw_before", 32'(st), 32'd2);
    chk("aw_gate_off", 32'(gate), 32'd0);
    tick();
    chk("att2_state", 32'(st), 32'd3);
    chk("att2_outs", 32'(outs()), 32'b01_10_101101);

    rp_sel_cfg = 2'd1;
    tick();
    chk("rpsel_follow", 32'(rpsel), 32'd1);
    chk("rpsel_state", 32'(st), 32'd3);

    vconn_allow = 1'b0;
    tick();
    chk("vconn_drop", 32'(vc1), 32'd0);
    vconn_allow = 1'b1;
    tick();
    chk("vconn_no_reentry", 32'(vc1), 32'd0);

    // short detach glitch
    vbus_safe0v = 1'b0;
    cc2_rd = 1'b0;
    tick();
    chk("dw_entry", 32'(st), 32'd4);
    chk("dw_att", 32'(att), 32'd1);
    chk("dw_gate", 32'(gate), 32'd1);
    for (int i = 0; i < TP - 3; i++) tick();
    cc2_rd = 1'b1;
    tick();
    chk("dw_restore", 32'(st), 32'd3);

    // full detach
    cc2_rd = 1'b0;
    tick();
    for (int i = 0; i < TP - 1; i++) tick();
    chk("dw_before", 32'(st), 32'd4);
    tick();
    chk("dchg_state", 32'(st), 32'd5);
    chk("dchg_gate", 32'(gate), 32'd0);
    chk("dchg_en", 32'(dchg), 32'd1);
    chk("dchg_vconn", 32'({vc1, vc2}), 32'd0);
    chk("dchg_rp", 32'({rp1, rp2}), 32'd3);
    chk("dchg_att", 32'(att), 32'd0);

    // discharge timeout with VBUS high
    for (int i = 0; i < TD - 1; i++) tick();
    chk("dchg_before", 32'(st), 32'd5);
    tick();
    chk("dchg_tmo", 32'(st), 32'd1);
    chk("dchg_tmo_en", 32'(dchg), 32'd0);
    chk("dchg_tmo_rp", 32'({rp1, rp2}), 32'd3);

    // attach on CC1 with Ra on CC2
    vbus_safe0v = 1'b1; cc1_rd = 1'b1; cc2_ra = 1'b1;
    tick();
    for (int i = 0; i < TC - 1; i++) tick();
    tick();
    chk("att1_state", 32'(st), 32'd3);
    chk("att1_outs", 32'(outs()), 32'b10_01_010101);

    // detach, VBUS reaches safe0V after 10 clk
    vbus_safe0v = 1'b0; cc1_rd = 1'b0;
    tick();
    for (int i = 0; i < TP - 1; i++) tick();
    tick();
    chk("dchg2_state", 32'(st), 32'd5);
    for (int i = 0; i < 10; i++) tick();
    chk("dchg2_hold", 32'(st), 32'd5);
    vbus_safe0v = 1'b1;
    tick();
    chk("dchg2_exit", 32'(st), 32'd1);
    chk("dchg2_en", 32'(dchg), 32'd0);

    // CC1 Rd glitch shorter than debounce
    gate_seen = 1'b0;
    cc1_rd = 1'b1;
    tick();
    gate_seen |= gate;
    for (int i = 0; i < TC - 3; i++) begin
      tick();
      gate_seen |= gate;
    end
    cc1_rd = 1'b0;
    tick();
    gate_seen |= gate;
    chk("glitch_state", 32'(st), 32'd1);
    chk("glitch_gate", 32'(gate_seen), 32'd0);

    // re-attach needs full debounce
    cc1_rd = 1'b1;
    tick();
    for (int i = 0; i < TC - 1; i++) tick();
    chk("reatt_before", 32'(st), 32'd2);
    tick();
    chk("reatt_state", 32'(st), 32'd3);

    // en=0 while attached
    en = 1'b0;
    tick();
    chk("en0_state", 32'(st), 32'd0);
    chk("en0_outs", 32'(outs()), 32'h000);
    en = 1'b1;
    tick();
    chk("en1_state", 32'(st), 32'd1);

    // srstz=0 while attached
    tick();
    for (int i = 0; i < TC - 1; i++) tick();
    tick();
    chk("att3_state", 32'(st), 32'd3);
    srstz = 1'b0;
    tick();
    chk("srst_state", 32'(st), 32'd0);
    chk("srst_outs", 32'(outs()), 32'h000);

    // en=0 beats a pending attach
    srstz = 1'b1;
    tick();
    chk("rel_state", 32'(st), 32'd1);
    en = 1'b0;
    tick();
    chk("en_wins", 32'(st), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
